fetch_prefetch_unit: RTL and testbench

Instruction fetch front end for the 5-stage MIPS pipeline. Owns the fetch PC, drives the combinational instruction memory, and buffers fetched words in a small prefetch FIFO. It presents {instruction, PC+4} to the fetch-to-decode pipeline register with a valid/stall handshake, so decode stalls no longer freeze the PC path. Branch, jump and jr targets resolved in decode arrive as a redirect that flushes the queue.

---
 rtl/fetch_prefetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction fetch front end for the 5-stage MIPS pipeline. It owns the
// fetch PC, drives the combinational instruction memory, and buffers each
// fetched word together with its PC+4 in a small prefetch FIFO. The FIFO head
// is presented to the fetch-to-decode register with a valid/stall handshake,
// so a decode stall only stops the FIFO from draining; it does not freeze
// fetching until the FIFO is full. Redirects resolved in decode flush the FIFO
// and restart fetching at the new target.
//
// Parameters
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded on reset
//
// Ports
//   Clk           system clock, rising edge
//   Reset         asynchronous active-low reset
//   Redirect      decode-resolved control transfer: flush and refetch
//   RedirectPC    target of Redirect (low two bits ignored)
//   DecodeStall   decode cannot accept the head entry this cycle
//   IMemAddr      instruction memory address (the fetch PC)
//   IMemData      instruction word for IMemAddr, same cycle
//   InstrValid    head entry valid
//   Instruction   head instruction word (zero when empty)
//   InstrPCPlus4  head entry PC+4 (zero when empty)
//   Occupancy     number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Redirect,
    input  logic [31:0]              RedirectPC,
    input  logic                     DecodeStall,
    output logic [31:0]              IMemAddr,
    input  logic [31:0]              IMemData,
    output logic                     InstrValid,
    output logic [31:0]              Instruction,
    output logic [31:0]              InstrPCPlus4,
    output logic [$clog2(DEPTH):0]   Occupancy
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      fetchPc;
    logic [31:0]      fetchPcPlus4;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;

    logic [31:0]      instrStore [DEPTH];
    logic [31:0]      pc4Store   [DEPTH];

    logic             headValid;
    logic             doPop;
    logic             doPush;

    assign fetchPcPlus4 = fetchPc + 32'd4;   // wraps 0xFFFFFFFC -> 0
    assign headValid    = (count != '0);

    // A redirect suppresses both sides of the FIFO: the head belongs to the
    // wrong path and so does the word currently on IMemData.
    assign doPop  = headValid & ~DecodeStall & ~Redirect;
    // When full, a push is still possible because the pop frees a slot on
    // the same edge.
    assign doPush = ~Redirect & ((count != FULL_COUNT) | doPop);

    // Control state: fetch PC, pointers and occupancy.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetchPc <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (Redirect) begin
            fetchPc <= {RedirectPC[31:2], 2'b00};
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            if (doPush) begin
                wrPtr   <= wrPtr + 1'b1;
                fetchPc <= fetchPcPlus4;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage. Each entry is cleared by reset so that nothing from
    // before a reset can ever reappear at the head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    instrStore[gi] <= '0;
                    pc4Store[gi]   <= '0;
                end else if (doPush && (wrPtr == PTR_W'(gi))) begin
                    instrStore[gi] <= IMemData;
                    pc4Store[gi]   <= fetchPcPlus4;
                end
            end
        end
    endgenerate

    // Show-ahead head; forced to zero when empty so stale entries never leak.
    always_comb begin
        InstrValid   = headValid;
        Instruction  = '0;
        InstrPCPlus4 = '0;
        if (headValid) begin
            Instruction  = instrStore[rdPtr];
            InstrPCPlus4 = pc4Store[rdPtr];
        end
    end

    assign IMemAddr  = fetchPc;
    assign Occupancy = count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//
// Self-checking bench for fetch_prefetch_unit (DEPTH=4, RESET_PC=0).
// Instruction memory is modelled as IMemData = IMemAddr ^ imemKey.
// Directed table vectors cover streaming, fill/stall, full with pop, redirect
// flush, redirect under stall and PC wrap; a hand-written sequence covers the
// asynchronous reset; a randomized phase is checked against a queue model.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        Reset;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        DecodeStall;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] InstrPCPlus4;
    logic [2:0]  Occupancy;

    logic [31:0] imemKey;

    int total;
    int bad;

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .DecodeStall  (DecodeStall),
        .IMemAddr     (IMemAddr),
        .IMemData     (IMemData),
        .InstrValid   (InstrValid),
        .Instruction  (Instruction),
        .InstrPCPlus4 (InstrPCPlus4),
        .Occupancy    (Occupancy)
    );

    assign IMemData = IMemAddr ^ imemKey;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        redirect;
        logic [31:0] redirectPc;
        logic        stall;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        logic [31:0] expOcc;
        logic [31:0] expAddr;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      modelQ[$];
    logic [31:0] modelPc;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic expValid,
                            input logic [31:0] expInstr, input logic [31:0] expPc4,
                            input logic [31:0] expOcc, input logic [31:0] expAddr);
        check({tag, ".valid"}, 32'(InstrValid), 32'(expValid));
        check({tag, ".instr"}, Instruction, expInstr);
        check({tag, ".pc4"},   InstrPCPlus4, expPc4);
        check({tag, ".occ"},   32'(Occupancy), expOcc);
        check({tag, ".addr"},  IMemAddr, expAddr);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        imemKey     = 32'h0;
        Reset       = 1'b0;
        Redirect    = 1'b0;
        RedirectPC  = 32'h0;
        DecodeStall = 1'b0;

        //                redir  target         stall valid instr          pc4            occ  addr
        vecs[0]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd1, 32'h0000_0004};
        vecs[1]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd2, 32'h0000_0008};
        vecs[2]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd3, 32'h0000_000C};
        vecs[3]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd4, 32'h0000_0010};
        vecs[4]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd4, 32'h0000_0010};
        vecs[5]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0004, 32'h0000_0008, 32'd4, 32'h0000_0014};
        vecs[6]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0004, 32'h0000_0008, 32'd4, 32'h0000_0014};
        vecs[7]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0008, 32'h0000_000C, 32'd4, 32'h0000_0018};
        vecs[8]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_000C, 32'h0000_0010, 32'd4, 32'h0000_001C};
        vecs[9]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0010, 32'h0000_0014, 32'd4, 32'h0000_0020};
        vecs[10] = '{1'b1, 32'h0000_0103,  1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'd0, 32'h0000_0100};
        vecs[11] = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0100, 32'h0000_0104, 32'd1, 32'h0000_0104};
        vecs[12] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0100, 32'h0000_0104, 32'd2, 32'h0000_0108};
        vecs[13] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0100, 32'h0000_0104, 32'd3, 32'h0000_010C};
        vecs[14] = '{1'b1, 32'h0000_0107,  1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'd0, 32'h0000_0104};
        vecs[15] = '{1'b1, 32'hFFFF_FFF8,  1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'd0, 32'hFFFF_FFF8};
        vecs[16] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd1, 32'hFFFF_FFFC};
        vecs[17] = '{1'b0, 32'h0,          1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'd1, 32'h0000_0000};
        vecs[18] = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd1, 32'h0000_0004};
        vecs[19] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'd2, 32'h0000_0008};

        // Reset state while reset is held.
        #12;
        checkAll("reset", 1'b0, 32'h0, 32'h0, 32'd0, 32'h0);
        $display("reset held: valid=%0b occ=%0d addr=0x%08h", InstrValid, Occupancy, IMemAddr);
        Reset = 1'b1;

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            Redirect    = vecs[i].redirect;
            RedirectPC  = vecs[i].redirectPc;
            DecodeStall = vecs[i].stall;
            @(posedge Clk);
            #1;
            checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expInstr,
                     vecs[i].expPc4, vecs[i].expOcc, vecs[i].expAddr);
            $display("vec%0d: redir=%0b stall=%0b -> valid=%0b instr=0x%08h pc4=0x%08h occ=%0d addr=0x%08h",
                     i, vecs[i].redirect, vecs[i].stall, InstrValid, Instruction,
                     InstrPCPlus4, Occupancy, IMemAddr);
        end

        // Asynchronous reset between edges with two entries queued.
        Redirect    = 1'b0;
        DecodeStall = 1'b1;
        #3;
        Reset = 1'b0;
        #1;
        checkAll("asyncrst", 1'b0, 32'h0, 32'h0, 32'd0, 32'h0);
        $display("async reset: valid=%0b instr=0x%08h occ=%0d addr=0x%08h",
                 InstrValid, Instruction, Occupancy, IMemAddr);
        #1;
        Reset       = 1'b1;
        DecodeStall = 1'b0;
        @(posedge Clk);
        #1;
        checkAll("restart", 1'b1, 32'h0, 32'h4, 32'd1, 32'h4);
        $display("restart: instr=0x%08h pc4=0x%08h occ=%0d", Instruction, InstrPCPlus4, Occupancy);

        // Randomized phase against a queue model. The model state mirrors the
        // known state right after the restart: one entry {0, 4}, PC = 4.
        modelQ.delete();
        modelQ.push_back('{32'h0, 32'h4});
        modelPc = 32'h4;
        imemKey = 32'hA5C3_0F00;

        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        rdir;
            logic        stl;
            logic [31:0] tgt;
            logic        mValid;
            logic        mPop;
            logic        mPush;
            entry_t      head;

            rdir = ($urandom_range(0, 9) == 0);
            stl  = ($urandom_range(0, 1) == 1);
            tgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom);
            Redirect    = rdir;
            RedirectPC  = tgt;
            DecodeStall = stl;

            // Model: what this edge does.
            mValid = (modelQ.size() != 0);
            mPop   = mValid && !stl && !rdir;
            mPush  = !rdir && ((modelQ.size() < DEPTH) || mPop);
            if (rdir) begin
                modelQ.delete();
                modelPc = tgt & 32'hFFFF_FFFC;
            end else begin
                if (mPop) begin
                    void'(modelQ.pop_front());
                end
                if (mPush) begin
                    modelQ.push_back('{modelPc ^ imemKey, modelPc + 32'd4});
                    modelPc = modelPc + 32'd4;
                end
            end

            @(posedge Clk);
            #1;
            if (modelQ.size() != 0) begin
                head = modelQ[0];
            end else begin
                head = '{32'h0, 32'h0};
            end
            checkAll($sformatf("rnd%0d", cyc), (modelQ.size() != 0), head.instr, head.pc4,
                     32'(modelQ.size()), modelPc);
            $display("rnd%0d: redir=%0b tgt=0x%08h stall=%0b -> valid=%0b instr=0x%08h pc4=0x%08h occ=%0d addr=0x%08h",
                     cyc, rdir, tgt, stl, InstrValid, Instruction, InstrPCPlus4, Occupancy, IMemAddr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
